// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline from ID through WB: carries decode controls, resolves the
// EX destination, and produces the load-use stall and EX-stage forwarding selects.
module ctrl_pipe #(
  parameter int unsigned REG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             RegDst_i,
  input  logic [1:0]       ALUOp_i,
  input  logic             ALUSrc_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             RegWrite_i,
  input  logic             MemToReg_i,
  input  logic [REG_W-1:0] IDrs_i,
  input  logic [REG_W-1:0] IDrt_i,
  input  logic [REG_W-1:0] IDrd_i,
  input  logic             Flush_i,
  output logic             Stall_o,
  output logic [1:0]       ALUOp_o,
  output logic             ALUSrc_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             RegWrite_o,
  output logic             MemToReg_o,
  output logic [REG_W-1:0] WBdst_o,
  output logic [1:0]       ForwardA_o,
  output logic [1:0]       ForwardB_o
);

  logic             ex_reg_dst;
  logic [1:0]       ex_alu_op;
  logic             ex_alu_src;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_reg_write;
  logic             ex_mem_to_reg;
  logic [REG_W-1:0] ex_rs;
  logic [REG_W-1:0] ex_rt;
  logic [REG_W-1:0] ex_rd;
  logic [REG_W-1:0] ex_dst;

  logic             mem_mem_read;
  logic             mem_mem_write;
  logic             mem_reg_write;
  logic             mem_mem_to_reg;
  logic [REG_W-1:0] mem_dst;

  logic             wb_reg_write;
  logic             wb_mem_to_reg;
  logic [REG_W-1:0] wb_dst;

  logic             bubble;

  assign ex_dst = ex_reg_dst ? ex_rd : ex_rt;

  // Conservative: compares against rt even when the ID instruction does not read it.
  always_comb begin
    Stall_o = 1'b0;
    if (ex_mem_read && (ex_dst != '0) && ((ex_dst == IDrs_i) || (ex_dst == IDrt_i)))
      Stall_o = 1'b1;
  end

  always_comb begin
    ForwardA_o = 2'b00;
    if (mem_reg_write && (mem_dst != '0) && (mem_dst == ex_rs))
      ForwardA_o = 2'b10;
    else if (wb_reg_write && (wb_dst != '0) && (wb_dst == ex_rs))
      ForwardA_o = 2'b01;
  end

  always_comb begin
    ForwardB_o = 2'b00;
    if (mem_reg_write && (mem_dst != '0) && (mem_dst == ex_rt))
      ForwardB_o = 2'b10;
    else if (wb_reg_write && (wb_dst != '0) && (wb_dst == ex_rt))
      ForwardB_o = 2'b01;
  end

  // Stall and flush together still collapse into one bubble.
  assign bubble = Stall_o | Flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_reg_dst     <= 1'b0;
      ex_alu_op      <= '0;
      ex_alu_src     <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_rs          <= '0;
      ex_rt          <= '0;
      ex_rd          <= '0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_dst        <= '0;
      wb_reg_write   <= 1'b0;
      wb_mem_to_reg  <= 1'b0;
      wb_dst         <= '0;
    end else begin
      if (bubble) begin
        ex_reg_dst    <= 1'b0;
        ex_alu_op     <= '0;
        ex_alu_src    <= 1'b0;
        ex_mem_read   <= 1'b0;
        ex_mem_write  <= 1'b0;
        ex_reg_write  <= 1'b0;
        ex_mem_to_reg <= 1'b0;
        ex_rs         <= '0;
        ex_rt         <= '0;
        ex_rd         <= '0;
      end else begin
        ex_reg_dst    <= RegDst_i;
        ex_alu_op     <= ALUOp_i;
        ex_alu_src    <= ALUSrc_i;
        ex_mem_read   <= MemRead_i;
        ex_mem_write  <= MemWrite_i;
        ex_reg_write  <= RegWrite_i;
        ex_mem_to_reg <= MemToReg_i;
        ex_rs         <= IDrs_i;
        ex_rt         <= IDrt_i;
        ex_rd         <= IDrd_i;
      end
      mem_mem_read   <= ex_mem_read;
      mem_mem_write  <= ex_mem_write;
      mem_reg_write  <= ex_reg_write;
      mem_mem_to_reg <= ex_mem_to_reg;
      mem_dst        <= ex_dst;
      wb_reg_write   <= mem_reg_write;
      wb_mem_to_reg  <= mem_mem_to_reg;
      wb_dst         <= mem_dst;
    end
  end

  assign ALUOp_o    = ex_alu_op;
  assign ALUSrc_o   = ex_alu_src;
  assign MemRead_o  = mem_mem_read;
  assign MemWrite_o = mem_mem_write;
  assign RegWrite_o = wb_reg_write;
  assign MemToReg_o = wb_mem_to_reg;
  assign WBdst_o    = wb_dst;

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe
Overview:
Consumer end of the main decoder's control bundle. Carries RegDst/ALUOp/ALUSrc/MemRead/MemWrite/RegWrite/MemToReg from ID through the ID/EX, EX/MEM and MEM/WB registers, and resolves the destination register in EX. Detects load-use hazards (stall plus bubble), applies branch/jump flushes, and produces EX-stage forwarding selects for the datapath.
Parameters:
REG_W, 5, register-number width (32-entry register file)
Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, asynchronous, active-low
RegDst_i  in  1  ID decode: 0 dst=rt, 1 dst=rd
ALUOp_i  in  2  ID decode ALU op class
ALUSrc_i  in  1  ID decode: 1 = immediate operand B
MemRead_i  in  1  ID decode load
MemWrite_i  in  1  ID decode store
RegWrite_i  in  1  ID decode register write
MemToReg_i  in  1  ID decode writeback from memory
IDrs_i  in  REG_W  rs field of ID instruction
IDrt_i  in  REG_W  rt field of ID instruction
IDrd_i  in  REG_W  rd field of ID instruction
Flush_i  in  1  taken branch/jump; squash the ID instruction
Stall_o  out  1  load-use hazard; hold PC and IF/ID (combinational)
ALUOp_o  out  2  EX-stage ALUOp
ALUSrc_o  out  1  EX-stage ALUSrc
MemRead_o  out  1  MEM-stage read enable
MemWrite_o  out  1  MEM-stage write enable
RegWrite_o  out  1  WB-stage register-file write enable
MemToReg_o  out  1  WB-stage writeback select
WBdst_o  out  REG_W  WB-stage destination register
ForwardA_o  out  2  EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
ForwardB_o  out  2  EX operand B select, same encoding
Behaviour:
- Reset (rst_i=0, asynchronous, may occur at any cycle): all pipeline registers clear to 0. Every output is 0: Stall_o=0, Forward*=00, WBdst_o=0. Clearing is immediate and independent of clk_i.
- ID/EX register: loads ID inputs each edge. It loads a bubble (all control bits 0, rs/rt/rd 0) when Stall_o=1 or Flush_i=1. Flush_i does not alter Stall_o. Top level gives Flush priority over the PC hold.
- EX destination: EXdst = EXRegDst ? EXrd : EXrt.
- EX/MEM and MEM/WB registers: advance every edge and are never stalled. They capture control bits plus dst.
- Latency: a bundle sampled at edge N drives EX outputs after N, MEM outputs after N+1, and WB outputs after N+2.
- Stall_o = EXMemRead & (EXdst!=0) & (EXdst==IDrs_i | EXdst==IDrt_i). This check is conservative and does not qualify on whether the ID instruction uses rt. Exactly one bubble per load-use pair.
- ForwardA: 10 if MEMRegWrite & MEMdst!=0 & MEMdst==EXrs. Otherwise 01 if WBRegWrite & WBdst!=0 & WBdst==EXrs. Otherwise 00. EX/MEM has priority over MEM/WB. ForwardB is the same rule using EXrt.
- Register 0: RegWrite to $0 propagates unchanged, but it never causes forwarding or a stall.
- Simultaneous Stall and Flush: a single bubble; no double insertion.
- Forward* and Stall_o are purely combinational from registered state and ID inputs.
Test Plan:
- Reset: hold rst_i=0 with toggling clk and random inputs -> all outputs 0. Release, feed R-type (RegDst=1, ALUOp=10, RegWrite=1, rd=3) -> ALUOp_o=10 after edge 1, RegWrite_o=1 and WBdst_o=3 after edge 3.
- Load-use: lw (MemRead=1, MemToReg=1, rt=5) followed by an add with rs=5 -> Stall_o=1 for exactly one cycle. The next EX shows ALUOp=00, ALUSrc=0 (bubble). The add then enters EX with ForwardA=01.
- Forwarding priority: add $2 ← ...; add $2 ← ...; add using rs=2, rt=2 -> ForwardA=10 and ForwardB=10 (EX/MEM wins over MEM/WB).
- $0 handling: R-type with rd=0, RegWrite=1, followed by a consumer of rs=0 -> Forward*=00. A lw with rt=0 followed by a user of rs=0 -> Stall_o=0.
- Flush: assert Flush_i with a store (MemWrite=1) in ID -> MemWrite_o stays 0 two cycles later. Flush coinciding with a load-use stall -> exactly one bubble.
- Async reset mid-stream: drop rst_i between edges with a lw in MEM -> MemRead_o=0 immediately, before the next edge.
